// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;
    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        SQUASH
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bundle: redirect input, instruction-memory port and decode handshake.
interface fetch_if #(
    parameter int XLEN = 32
);
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_read;
    logic [XLEN-1:0] imem_addr;
    logic            imem_resp;
    logic [XLEN-1:0] imem_rdata;
    logic            dec_valid;
    logic [XLEN-1:0] dec_inst;
    logic [XLEN-1:0] dec_pc;
    logic            dec_ready;

    modport master (
        input  redirect, redirect_pc, imem_resp, imem_rdata, dec_ready,
        output imem_read, imem_addr, dec_valid, dec_inst, dec_pc
    );

    modport slave (
        output redirect, redirect_pc, imem_resp, imem_rdata, dec_ready,
        input  imem_read, imem_addr, dec_valid, dec_inst, dec_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular-buffer FIFO of fetched {pc, inst} pairs; head is read straight from storage.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  QDEPTH  = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enq,
    input  entry_t                 enq_data,
    input  logic                   deq,
    input  logic                   flush,
    output logic [$clog2(QDEPTH):0] count,
    output logic                   head_valid,
    output entry_t                 head
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH) + 1;

    entry_t          mem [QDEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_enq;
    logic            do_deq;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Flush kills the head, so a same-cycle dequeue or enqueue is dropped.
    assign do_deq = deq && (count != '0) && !flush;
    assign do_enq = enq && !flush && ((count != CW'(QDEPTH)) || do_deq);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                mem[wr_ptr] <= enq_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_deq) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_valid = (count != '0);
    assign head       = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC/pend registers, request FSM with squash, and a fetch queue.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0060),
    parameter int              QDEPTH   = 2
) (
    input logic     clk,
    input logic     reset,
    fetch_if.master bus
);
    localparam int CW = $clog2(QDEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pend;
    logic [XLEN-1:0] target;
    logic            read_q;
    logic [CW-1:0]   count;
    logic            head_valid;
    entry_t          head;
    entry_t          enq_data;
    logic            enq;
    logic            deq;
    logic            room_after;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

    assign target     = align_pc(bus.redirect_pc);
    assign enq        = (state == BUSY) && bus.imem_resp && !bus.redirect;
    assign deq        = head_valid && bus.dec_ready;
    assign enq_data   = '{pc: pc, inst: bus.imem_rdata};
    // Occupancy after this cycle's enqueue/dequeue; another request only if a slot stays free.
    assign room_after = (int'(count) + 1 - int'(deq)) < QDEPTH;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            pend   <= RESET_PC;
            read_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.redirect) begin
                        pc     <= target;
                        state  <= BUSY;
                        read_q <= 1'b1;
                    end else if (int'(count) < QDEPTH) begin
                        state  <= BUSY;
                        read_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (bus.imem_resp) begin
                        if (bus.redirect) begin
                            pc <= target;
                        end else begin
                            pc <= pc + XLEN'(INST_BYTES);
                            if (!room_after) begin
                                state  <= IDLE;
                                read_q <= 1'b0;
                            end
                        end
                    end else if (bus.redirect) begin
                        pend  <= target;
                        state <= SQUASH;
                    end
                end
                SQUASH: begin
                    // The stale response must drain before the new address may go out.
                    if (bus.imem_resp) begin
                        pc    <= bus.redirect ? target : pend;
                        state <= BUSY;
                    end else if (bus.redirect) begin
                        pend <= target;
                    end
                end
                default: begin
                    state  <= IDLE;
                    read_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH),
        .entry_t(entry_t)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .enq       (enq),
        .enq_data  (enq_data),
        .deq       (deq),
        .flush     (bus.redirect),
        .count     (count),
        .head_valid(head_valid),
        .head      (head)
    );

    assign bus.imem_read = read_q;
    assign bus.imem_addr = pc;
    assign bus.dec_valid = head_valid;
    assign bus.dec_inst  = head.inst;
    assign bus.dec_pc    = head.pc;

endmodule
